// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the ALU datapath and the
// result checker, plus the checker's run-state encoding.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_NOT = 3'b011,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Golden ALU function: combinational expected result for (a, b, op).
// All results are modulo 2^WIDTH; carry, borrow and shifted-out bits drop.
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_result
);

   // Opcode decode to the reference result
   always_comb begin
      o_result = '0;
      case (i_op)
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NOT:  o_result = ~i_a;
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_SHL:  o_result = {i_a[WIDTH-2:0], 1'b0};
         OP_SHR:  o_result = {1'b0, i_a[WIDTH-1:1]};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_result_checker.sv
// Receiving end of the ALU test-vector stream. Stage 1 registers each
// accepted transaction; stage 2 compares it against the reference model,
// updates saturating pass/fail counters and latches the first mismatch.
module alu_result_checker
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_last,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             err_valid,
   output logic [WIDTH-1:0] err_a,
   output logic [WIDTH-1:0] err_b,
   output logic [2:0]       err_op,
   output logic [WIDTH-1:0] err_expected,
   output logic [WIDTH-1:0] err_actual,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_e       r_state;
   chk_state_e       w_state_nxt;
   logic             r_last_seen;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_result;
   logic             r_s1_last;

   logic [CNT_W-1:0] r_pass;
   logic [CNT_W-1:0] r_fail;
   logic             r_err_valid;
   logic [WIDTH-1:0] r_err_a;
   logic [WIDTH-1:0] r_err_b;
   logic [2:0]       r_err_op;
   logic [WIDTH-1:0] r_err_expected;
   logic [WIDTH-1:0] r_err_actual;

   logic             w_soft_rst;
   logic             w_accept;
   logic             w_retire_last;
   logic             w_mismatch;
   logic [WIDTH-1:0] w_expected;

   // Reset and clear are equivalent; either one also blocks an accept that
   // coincides with it, since every pipeline register is forced to idle.
   assign w_soft_rst    = !rst_n || clear;
   assign in_ready      = !r_last_seen;
   assign w_accept      = in_valid && in_ready;
   assign w_retire_last = r_s1_valid && r_s1_last;
   assign w_mismatch    = (w_expected != r_s1_result);

   alu_ref_model #(
      .WIDTH (WIDTH)
   ) u_ref (
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .i_op     (r_s1_op),
      .o_result (w_expected)
   );

   // Run-state register
   always_ff @(posedge clk) begin
      if (w_soft_rst) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Run-state transitions: first accept starts a run, retiring the last
   // transaction ends it; only reset/clear leaves DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)      w_state_nxt = ST_RUN;
         ST_RUN:  if (w_retire_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Input gate: once a last transaction is taken, nothing more is accepted
   always_ff @(posedge clk) begin
      if (w_soft_rst)                r_last_seen <= 1'b0;
      else if (w_accept && in_last)  r_last_seen <= 1'b1;
   end

   // Stage 1: capture the accepted transaction
   always_ff @(posedge clk) begin
      if (w_soft_rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_op     <= '0;
         r_s1_result <= '0;
         r_s1_last   <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a      <= in_a;
            r_s1_b      <= in_b;
            r_s1_op     <= in_op;
            r_s1_result <= in_result;
            r_s1_last   <= in_last;
         end
      end
   end

   // Stage 2: compare, count with saturation, latch first mismatch only
   always_ff @(posedge clk) begin
      if (w_soft_rst) begin
         r_pass         <= '0;
         r_fail         <= '0;
         r_err_valid    <= 1'b0;
         r_err_a        <= '0;
         r_err_b        <= '0;
         r_err_op       <= '0;
         r_err_expected <= '0;
         r_err_actual   <= '0;
      end else if (r_s1_valid) begin
         if (w_mismatch) begin
            if (r_fail != CNT_MAX) r_fail <= r_fail + CNT_W'(1);
            if (!r_err_valid) begin
               r_err_valid    <= 1'b1;
               r_err_a        <= r_s1_a;
               r_err_b        <= r_s1_b;
               r_err_op       <= r_s1_op;
               r_err_expected <= w_expected;
               r_err_actual   <= r_s1_result;
            end
         end else if (r_pass != CNT_MAX) begin
            r_pass <= r_pass + CNT_W'(1);
         end
      end
   end

   assign pass_count   = r_pass;
   assign fail_count   = r_fail;
   assign err_valid    = r_err_valid;
   assign err_a        = r_err_a;
   assign err_b        = r_err_b;
   assign err_op       = r_err_op;
   assign err_expected = r_err_expected;
   assign err_actual   = r_err_actual;
   assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: directed scenarios plus randomized runs,
// scored against an arithmetic reference model. A second instance with
// 2-bit counters shares the stimulus to exercise saturation.
module tb_alu_result_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [3:0] in_a, in_b, in_result;
   logic [2:0] in_op;
   logic       in_last;

   logic        in_ready, err_valid, done;
   logic [15:0] pass_count, fail_count;
   logic [3:0]  err_a, err_b, err_expected, err_actual;
   logic [2:0]  err_op;

   logic        in_ready_s, err_valid_s, done_s;
   logic [1:0]  pass_count_s, fail_count_s;
   logic [3:0]  err_a_s, err_b_s, err_expected_s, err_actual_s;
   logic [2:0]  err_op_s;

   always #5 clk = ~clk;

   alu_result_checker #(.WIDTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .in_result(in_result), .in_last(in_last),
      .pass_count(pass_count), .fail_count(fail_count),
      .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_op(err_op),
      .err_expected(err_expected), .err_actual(err_actual), .done(done)
   );

   alu_result_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .in_result(in_result), .in_last(in_last),
      .pass_count(pass_count_s), .fail_count(fail_count_s),
      .err_valid(err_valid_s), .err_a(err_a_s), .err_b(err_b_s), .err_op(err_op_s),
      .err_expected(err_expected_s), .err_actual(err_actual_s), .done(done_s)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   int         m_pass, m_fail, m_pass_s, m_fail_s;
   bit         m_errv, m_ready, m_done;
   logic [3:0] m_ea, m_eb, m_eexp, m_eact;
   logic [2:0] m_eop;

   function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      int ia = int'(a);
      int ib = int'(b);
      int r  = 0;
      case (op)
         3'd0: r = int'(a & b);
         3'd1: r = int'(a | b);
         3'd2: r = int'(a ^ b);
         3'd3: r = 15 - ia;
         3'd4: r = (ia + ib) % 16;
         3'd5: r = (ia - ib + 16) % 16;
         3'd6: r = (ia * 2) % 16;
         3'd7: r = ia / 2;
         default: r = 0;
      endcase
      return r[3:0];
   endfunction

   task automatic model_clear();
      m_pass = 0; m_fail = 0; m_pass_s = 0; m_fail_s = 0;
      m_errv = 0; m_ready = 1; m_done = 0;
      m_ea = '0; m_eb = '0; m_eop = '0; m_eexp = '0; m_eact = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Present one transaction for one cycle; the model scores it if accepted.
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] res, input logic last);
      logic [3:0] e;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_result = res; in_last = last;
      @(posedge clk);
      if (m_ready) begin
         e = ref_alu(a, b, op);
         if (e == res) begin
            m_pass++;
            if (m_pass_s < 3) m_pass_s++;
         end else begin
            m_fail++;
            if (m_fail_s < 3) m_fail_s++;
            if (!m_errv) begin
               m_errv = 1; m_ea = a; m_eb = b; m_eop = op; m_eexp = e; m_eact = res;
            end
         end
         if (last) begin
            m_ready = 0;
            m_done  = 1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_clear();
      in_valid = 1'b0;
      clear    = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      model_clear();
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pass"},     pass_count,   m_pass);
      chk({tag, ".fail"},     fail_count,   m_fail);
      chk({tag, ".err_valid"}, err_valid,   m_errv);
      chk({tag, ".err_a"},    err_a,        m_ea);
      chk({tag, ".err_b"},    err_b,        m_eb);
      chk({tag, ".err_op"},   err_op,       m_eop);
      chk({tag, ".err_exp"},  err_expected, m_eexp);
      chk({tag, ".err_act"},  err_actual,   m_eact);
      chk({tag, ".done"},     done,         m_done);
      chk({tag, ".in_ready"}, in_ready,     m_ready);
      chk({tag, ".sat_pass"}, pass_count_s, m_pass_s);
      chk({tag, ".sat_fail"}, fail_count_s, m_fail_s);
   endtask

   task automatic random_run(input int n);
      logic [3:0] a, b, e, r;
      logic [2:0] op;
      for (int i = 0; i < n; i++) begin
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 15));
         op = 3'($urandom_range(0, 7));
         e  = ref_alu(a, b, op);
         r  = ($urandom_range(0, 3) == 0) ? (e ^ 4'($urandom_range(1, 15))) : e;
         send(a, b, op, r, (i == n - 1));
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_result = '0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("reset");

      // All-correct XOR run with latency checks
      send(4'h0, 4'h0, 3'd2, 4'h0, 1'b0);
      send(4'hF, 4'h1, 3'd2, 4'hE, 1'b0);
      send(4'hA, 4'hC, 3'd2, 4'h6, 1'b0);
      send(4'hF, 4'hF, 3'd2, 4'h0, 1'b1);
      chk("xor.ready_after_last", in_ready, 1'b0);
      chk("xor.done_early", done, 1'b0);
      chk("xor.pass_early", pass_count, 32'd3);
      @(negedge clk);
      chk("xor.done_on_time", done, 1'b1);
      chk("xor.pass_final", pass_count, 32'd4);
      check_all("xor");

      // Backpressure after last: new data offered, nothing taken
      send(4'h3, 4'h5, 3'd4, 4'h0, 1'b0);
      send(4'h3, 4'h5, 3'd4, 4'h8, 1'b1);
      send(4'h1, 4'h2, 3'd0, 4'hF, 1'b0);
      idle(2);
      check_all("backpressure");
      do_clear();
      check_all("after_clear");

      // First-error latch
      send(4'hA, 4'hC, 3'd0, 4'h8, 1'b0);
      send(4'h7, 4'h1, 3'd4, 4'h0, 1'b0);
      send(4'h1, 4'h1, 3'd2, 4'hF, 1'b1);
      idle(2);
      check_all("first_err");
      chk("first_err.expected_const", err_expected, 4'h8);
      chk("first_err.fail_const", fail_count, 32'd2);
      do_clear();

      // Arithmetic wrap
      send(4'hF, 4'h1, 3'd4, 4'h0, 1'b0);
      send(4'h0, 4'h1, 3'd5, 4'hF, 1'b0);
      send(4'h8, 4'h0, 3'd6, 4'h0, 1'b1);
      idle(2);
      check_all("wrap");
      chk("wrap.pass_const", pass_count, 32'd3);
      do_clear();

      // Clear colliding with a valid transaction: dropped
      in_valid = 1'b1; in_a = 4'h2; in_b = 4'h3; in_op = 3'd1; in_result = 4'h3; in_last = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      model_clear();
      idle(2);
      check_all("clear_collision");

      // Reset while two transactions are in flight
      in_valid = 1'b1; in_a = 4'h4; in_b = 4'h4; in_op = 3'd0; in_result = 4'h4;
      @(negedge clk);
      in_a = 4'h5; in_op = 3'd7; in_result = 4'h2;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      model_clear();
      idle(2);
      check_all("midrun_reset");

      // Saturation in the 2-bit-counter instance
      for (int i = 0; i < 5; i++)
         send(4'(i + 3), 4'h6, 3'(i), ref_alu(4'(i + 3), 4'h6, 3'(i)), (i == 4));
      idle(2);
      check_all("sat_pass");
      chk("sat_pass.const", pass_count_s, 2'b11);
      do_clear();
      for (int i = 0; i < 5; i++)
         send(4'(i), 4'h9, 3'(i + 2), ~ref_alu(4'(i), 4'h9, 3'(i + 2)), (i == 4));
      idle(2);
      check_all("sat_fail");
      do_clear();

      // Randomized runs
      for (int r = 0; r < 4; r++) begin
         random_run(30 + r * 10);
         check_all($sformatf("random%0d", r));
         do_clear();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
